// File: rtl/wb_periph_bridge.sv
// rtl/wb_periph_bridge.sv - registered Wishbone classic bridge decoding one address field into NS slave strobes.
// Optional hung-slave timeout enabled by defining WB_BRIDGE_TIMEOUT_EN.
module wb_periph_bridge #(
    parameter int          NS       = 2,
    parameter int          SEL_LSB  = 16,
    parameter int          SEL_W    = 1,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             s_cyc_o,
    output logic [NS-1:0]    s_stb_o,
    output logic             s_we_o,
    output logic [3:0]       s_sel_o,
    output logic [31:0]      s_adr_o,
    output logic [31:0]      s_dat_o,
    input  logic [NS-1:0]    s_ack_i,
    input  logic [NS*32-1:0] s_dat_i,
    output logic             err_o
);

    typedef enum logic [1:0] {IDLE, FWD, RESP} state_t;

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  idx_q;
    logic [31:0]       adr_q, dat_q, rdata_q;
    logic [3:0]        sel_q;
    logic              we_q, err_q;

    logic [31:0]       req_idx_ext;
    logic              req_mapped;
    logic [NS-1:0]     stb_vec;
    logic              hit_ack;
    logic [31:0]       hit_dat;
    logic              timeout_hit;

    logic              ld_req, ld_resp, resp_err;
    logic [31:0]       resp_dat;

    assign req_idx_ext = 32'(wbs_adr_i[SEL_LSB +: SEL_W]);
    assign req_mapped  = req_idx_ext < 32'(NS);

    // Mux the selected slave's ack/data by comparison so out-of-range indices never index the vectors.
    always_comb begin
        stb_vec = '0;
        hit_ack = 1'b0;
        hit_dat = '0;
        for (int k = 0; k < NS; k++) begin
            if (32'(idx_q) == k) begin
                stb_vec[k] = 1'b1;
                hit_ack    = s_ack_i[k];
                hit_dat    = s_dat_i[32*k +: 32];
            end
        end
    end

`ifdef WB_BRIDGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;

    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            cnt_q <= '0;
        end else if (state == FWD) begin
            if (cnt_q != CW'(TIMEOUT))
                cnt_q <= cnt_q + CW'(1);
        end else begin
            cnt_q <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        ld_req    = 1'b0;
        ld_resp   = 1'b0;
        resp_err  = 1'b0;
        resp_dat  = '0;
        case (state)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    ld_req = 1'b1;
                    if (req_mapped) begin
                        state_nxt = FWD;
                    end else begin
                        state_nxt = RESP;
                        ld_resp   = 1'b1;
                        resp_err  = 1'b1;
                        resp_dat  = ERR_DATA;
                    end
                end
            end
            FWD: begin
                // Host abort wins over everything; a slave ack beats a same-cycle timeout.
                if (!wbs_cyc_i) begin
                    state_nxt = IDLE;
                end else if (hit_ack) begin
                    state_nxt = RESP;
                    ld_resp   = 1'b1;
                    resp_dat  = hit_dat;
                end else if (timeout_hit) begin
                    state_nxt = RESP;
                    ld_resp   = 1'b1;
                    resp_err  = 1'b1;
                    resp_dat  = ERR_DATA;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state   <= IDLE;
            idx_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ld_req) begin
                idx_q <= wbs_adr_i[SEL_LSB +: SEL_W];
                adr_q <= wbs_adr_i;
                dat_q <= wbs_dat_i;
                sel_q <= wbs_sel_i;
                we_q  <= wbs_we_i;
            end
            if (ld_resp) begin
                rdata_q <= resp_dat;
                err_q   <= resp_err;
            end
        end
    end

    assign wbs_ack_o = (state == RESP);
    assign wbs_dat_o = wbs_ack_o ? rdata_q : 32'h0;
    assign err_o     = wbs_ack_o & err_q;
    assign s_cyc_o   = (state == FWD);
    assign s_stb_o   = s_cyc_o ? stb_vec : '0;
    assign s_we_o    = we_q;
    assign s_sel_o   = sel_q;
    assign s_adr_o   = adr_q;
    assign s_dat_o   = dat_q;

endmodule

// File: tb/tb_wb_periph_bridge.sv
// tb/tb_wb_periph_bridge.sv - randomized self-checking bench for wb_periph_bridge.
module tb_wb_periph_bridge;

    localparam int NS      = 2;
    localparam int SEL_LSB = 16;
    localparam int SEL_W   = 2;
    localparam int TMO     = 4;
`ifdef WB_BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cyc, stb, we;
    logic [3:0]       sel;
    logic [31:0]      adr, wdat;
    logic             ack;
    logic [31:0]      rdat;
    logic             s_cyc;
    logic [NS-1:0]    s_stb;
    logic             s_we;
    logic [3:0]       s_sel;
    logic [31:0]      s_adr, s_dat;
    logic [NS-1:0]    s_ack;
    logic [NS*32-1:0] s_rdat;
    logic             err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_periph_bridge #(
        .NS(NS), .SEL_LSB(SEL_LSB), .SEL_W(SEL_W), .TIMEOUT(TMO), .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_adr_o(s_adr), .s_dat_o(s_dat), .s_ack_i(s_ack), .s_dat_i(s_rdat),
        .err_o(err)
    );

    // One host transfer; the slave acks on FWD cycle d (d beyond TMO means a hung slave when
    // timeouts are built in). pre = idle cycles before the request is sampled; chain leaves the
    // bus asserted so the caller can issue the next request in the ack cycle.
    task automatic do_xfer(input logic [31:0] a, input logic wr, input int d,
                           input logic [31:0] slv_dat, input int pre, input bit chain);
        int               idx, strobes, ack_n, last_n;
        bit               mapped, to, fwd, exp_ack, exp_err;
        logic [31:0]      exp_dat, wd;
        logic [3:0]       sl;
        logic [NS-1:0]    onehot, av;
        idx     = int'(a[SEL_LSB +: SEL_W]);
        mapped  = idx < NS;
        to      = mapped && TO_EN && d > TMO;
        strobes = !mapped ? 0 : (to ? TMO : d);
        ack_n   = pre + (mapped ? strobes + 1 : 1);
        last_n  = ack_n + (chain ? 0 : 1);
        exp_err = !mapped || to;
        exp_dat = exp_err ? 32'hDEADBEEF : slv_dat;
        onehot  = '0;
        if (mapped) onehot[idx] = 1'b1;
        wd  = $urandom;
        sl  = 4'($urandom);
        cyc = 1'b1; stb = 1'b1; we = wr; adr = a; wdat = wd; sel = sl;
        for (int n = 1; n <= last_n; n++) begin
            @(negedge clk);
            fwd     = mapped && n > pre && n <= pre + strobes;
            exp_ack = (n == ack_n);
            total++;
            if (s_cyc !== fwd) begin
                bad++; $display("FAIL xfer_s_cyc n=%0d got=%b exp=%b", n, s_cyc, fwd);
            end
            total++;
            if (s_stb !== (fwd ? onehot : '0)) begin
                bad++; $display("FAIL xfer_s_stb n=%0d got=%b exp=%b", n, s_stb, fwd ? onehot : '0);
            end
            if (fwd) begin
                total++;
                if ({s_adr, s_dat, s_sel, s_we} !== {a, wd, sl, wr}) begin
                    bad++; $display("FAIL xfer_latched n=%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b",
                                    n, s_adr, s_dat, s_sel, s_we, a, wd, sl, wr);
                end
            end
            total++;
            if (ack !== exp_ack) begin
                bad++; $display("FAIL xfer_ack n=%0d got=%b exp=%b", n, ack, exp_ack);
            end
            total++;
            if (err !== (exp_ack && exp_err)) begin
                bad++; $display("FAIL xfer_err n=%0d got=%b exp=%b", n, err, exp_ack && exp_err);
            end
            total++;
            if (rdat !== (exp_ack ? exp_dat : 32'h0)) begin
                bad++; $display("FAIL xfer_dat n=%0d got=%h exp=%h", n, rdat, exp_ack ? exp_dat : 32'h0);
            end
            av     = NS'($urandom) & ~onehot;
            s_rdat = {$urandom, $urandom};
            if (fwd && n == pre + d) begin
                av[idx] = 1'b1;
                s_rdat[32*idx +: 32] = slv_dat;
            end
            s_ack = av;
            if (n == ack_n && !chain) begin
                cyc = 1'b0; stb = 1'b0;
            end
        end
        if (!chain) s_ack = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({ack, rdat, s_cyc, s_stb, err} !== '0) begin
            bad++; $display("FAIL reset_host_side got=%b/%h/%b/%b/%b exp=0", ack, rdat, s_cyc, s_stb, err);
        end
        total++;
        if ({s_we, s_sel, s_adr, s_dat} !== '0) begin
            bad++; $display("FAIL reset_latched got=%b/%h/%h/%h exp=0", s_we, s_sel, s_adr, s_dat);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_slave1();
        do_xfer(32'h0001_0040, 1'b0, 2, 32'h1234_5678, 0, 1'b0);
    endtask

    task automatic test_write_slave0();
        do_xfer(32'h0000_0008, 1'b1, 3, 32'hA5A5_0001, 0, 1'b0);
    endtask

    task automatic test_unmapped();
        do_xfer(32'h0003_0000, 1'b0, 1, 32'h0, 0, 1'b0);
        do_xfer(32'h0002_0010, 1'b1, 1, 32'h0, 0, 1'b0);
    endtask

    task automatic test_timeout();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0000_0100; s_ack = '0;
        for (int n = 1; n <= 110; n++) begin
            @(negedge clk);
            if (TO_EN && n > TMO) begin
                total++;
                if ({s_stb, ack, err, rdat} !== {2'b00, (n == TMO + 1), (n == TMO + 1),
                                                  (n == TMO + 1) ? 32'hDEADBEEF : 32'h0}) begin
                    bad++; $display("FAIL timeout_resp n=%0d got=%b/%b/%b/%h", n, s_stb, ack, err, rdat);
                end
                cyc = 1'b0; stb = 1'b0;
                if (n == TMO + 2) break;
            end else begin
                total++;
                if ({s_stb, ack} !== {2'b01, 1'b0}) begin
                    bad++; $display("FAIL timeout_wait n=%0d got=%b/%b exp=01/0", n, s_stb, ack);
                end
            end
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        total++;
        if ({s_cyc, ack} !== 2'b00) begin
            bad++; $display("FAIL timeout_release got=%b/%b exp=0/0", s_cyc, ack);
        end
    endtask

    task automatic test_abort();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0001_0000; s_ack = '0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (s_stb !== 2'b10) begin
            bad++; $display("FAIL abort_fwd got=%b exp=10", s_stb);
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        total++;
        if ({s_cyc, s_stb, ack} !== 4'b0) begin
            bad++; $display("FAIL abort_idle got=%b/%b/%b exp=0", s_cyc, s_stb, ack);
        end
        s_ack = 2'b10; s_rdat = {32'hBAD0_0001, 32'h0};
        @(negedge clk);
        s_ack = '0;
        total++;
        if ({ack, err, rdat} !== '0) begin
            bad++; $display("FAIL abort_late_ack got=%b/%b/%h exp=0", ack, err, rdat);
        end
        do_xfer(32'h0001_0004, 1'b0, 1, 32'h0BAD_CAFE, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0000_0020; wdat = 32'h5555_AAAA; s_ack = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        total++;
        if ({ack, rdat, s_cyc, s_stb, err, s_we, s_sel, s_adr, s_dat} !== '0) begin
            bad++; $display("FAIL reset_mid_outputs got=%b/%h/%b/%b/%b/%h", ack, rdat, s_cyc, s_stb, err, s_adr);
        end
        rst_n = 1'b1; s_ack = 2'b01; s_rdat = {32'h0, 32'h7777_7777};
        @(negedge clk);
        s_ack = '0;
        total++;
        if ({ack, s_cyc} !== 2'b00) begin
            bad++; $display("FAIL reset_mid_late_ack got=%b/%b exp=0/0", ack, s_cyc);
        end
        do_xfer(32'h0000_0024, 1'b0, 2, 32'h1357_9BDF, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_xfer(32'h0000_0000, 1'b0, 1, 32'h1111_1111, 0, 1'b1);
        do_xfer(32'h0001_0000, 1'b1, 1, 32'h2222_2222, 1, 1'b1);
        do_xfer(32'h0003_0000, 1'b0, 1, 32'h0, 1, 1'b1);
        do_xfer(32'h0000_0004, 1'b0, 2, 32'h3333_3333, 1, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            a[SEL_LSB +: SEL_W] = 2'($urandom_range(0, 3));
            do_xfer(a, 1'($urandom), $urandom_range(1, 6), $urandom, 0, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
        adr = '0; wdat = '0; s_ack = '0; s_rdat = '0;
        test_reset();
        test_read_slave1();
        test_write_slave0();
        test_unmapped();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
